// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES equal slices,
// one slice per register stage, behind a valid/ready handshake that stalls the whole pipe.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int S    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic              carry_q [STAGES];
    logic              ovf_q;

    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic              c_in    [STAGES];
    logic [S:0]        slice   [STAGES];
    logic              carry_d [STAGES];
    logic              ovf_d;
    logic              stall;

    assign stall    = valid_q[LAST] && !out_ready;
    assign in_ready = !stall;

    // Each stage carries the full operands and the partial sum forward; stage k fills
    // bits [k*S +: S] of the sum using the carry registered by stage k-1.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
        a_d[0]   = ina;
        b_d[0]   = sub ? ~inb : inb;
        sum_d[0] = '0;
        c_in[0]  = sub ? ~cin : cin;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sum_d[k] = sum_q[k-1];
            c_in[k]  = carry_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice[k]            = {1'b0, a_d[k][k*S +: S]} + {1'b0, b_d[k][k*S +: S]}
                                + {{S{1'b0}}, c_in[k]};
            sum_d[k][k*S +: S]  = slice[k][S-1:0];
            carry_d[k]          = slice[k][S];
        end
        ovf_d = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
             && (sum_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the old value of its predecessor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are cleared too, so sum/cout/ovf read zero out of reset.
            valid_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed scenarios plus
// randomised handshake traffic scored against an arithmetic reference model.
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ina = '0;
    logic [15:0] inb = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t exp_q[$];

    logic        obs_valid, obs_in_ready, obs_cout, obs_ovf;
    logic [15:0] obs_sum;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_sum;
    logic        prev_cout, prev_ovf;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ina(ina), .inb(inb), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: true integer arithmetic; sub is a - b - c, overflow is the signed result leaving 16-bit range.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
        res_t r;
        int   total, sa, sb, st;
        sa = $signed(a);
        sb = $signed(b);
        if (!s) begin
            total  = int'(a) + int'(b) + int'(c);
            r.cout = (total >= 65536);
            st     = sa + sb + int'(c);
        end else begin
            total  = int'(a) - int'(b) - int'(c);
            r.cout = (total >= 0);
            st     = sa - sb - int'(c);
        end
        r.sum = total[15:0];
        r.ovf = (st > 32767) || (st < -32768);
        return r;
    endfunction

    // One clock cycle: drive just after negedge, sample 1ns later, score, then advance to next negedge.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic r);
        res_t e;
        in_valid = v; ina = a; inb = b; cin = c; sub = s; out_ready = r;
        #1;
        obs_valid = out_valid; obs_sum = sum; obs_cout = cout; obs_ovf = ovf; obs_in_ready = in_ready;
        if (prev_stall) begin
            n_cmp++;
            if (out_valid !== 1'b1 || sum !== prev_sum || cout !== prev_cout || ovf !== prev_ovf) begin
                n_err++;
                $display("FAIL hold_stable: got v=%b sum=%h cout=%b ovf=%b, want v=1 sum=%h cout=%b ovf=%b",
                         out_valid, sum, cout, ovf, prev_sum, prev_cout, prev_ovf);
            end
        end
        if (out_valid === 1'b1 && r) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard: unexpected result sum=%h, want no result", sum);
            end else begin
                e = exp_q.pop_front();
                if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                    n_err++;
                    $display("FAIL scoreboard: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
        if (v && in_ready === 1'b1) exp_q.push_back(model(a, b, c, s));
        prev_stall = (out_valid === 1'b1) && !r;
        prev_sum = sum; prev_cout = cout; prev_ovf = ovf;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_single(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic c, input logic s,
                              input logic [15:0] es, input logic ec, input logic eo);
        for (int k = 0; k <= 7; k++) begin
            if (k == 0) step(1'b1, a, b, c, s, 1'b1);
            else        step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (obs_valid !== (k == STAGES)) begin
                n_err++;
                $display("FAIL %s out_valid at +%0d: got %b want %b", name, k, obs_valid, (k == STAGES));
            end
            if (k == STAGES) begin
                n_cmp++;
                if (obs_sum !== es || obs_cout !== ec || obs_ovf !== eo) begin
                    n_err++;
                    $display("FAIL %s result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             name, obs_sum, obs_cout, obs_ovf, es, ec, eo);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        exp_q.delete(); prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b sum=%h cout=%b ovf=%b, want all zero", out_valid, sum, cout, ovf);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        run_single("basic_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    endtask

    task automatic test_carry();
        run_single("carry_wrap", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("carry_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_sub();
        run_single("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int got_t[$];
        logic [15:0] got_s[$];
        logic [15:0] exp_s;
        for (int t = 0; t < 14; t++) begin
            if (t < 8) step(1'b1, 16'(t + 1), 16'(16'h0100 * (t + 1)), 1'b0, 1'b0, 1'b1);
            else       step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            if (obs_valid === 1'b1) begin
                got_t.push_back(t);
                got_s.push_back(obs_sum);
            end
        end
        n_cmp++;
        if (got_t.size() != 8) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results want 8", got_t.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_s = 16'((i + 1) + 16'h0100 * (i + 1));
                n_cmp++;
                if (got_t[i] != STAGES + i || got_s[i] !== exp_s) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got cycle %0d sum=%h, want cycle %0d sum=%h",
                             i, got_t[i], got_s[i], STAGES + i, exp_s);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ea[6];
        logic [15:0] eb[6];
        res_t        exp_l[6];
        res_t        got[$];
        res_t        g;
        int          sent = 0;
        int          stalls = 0;
        logic        r, v;
        for (int j = 0; j < 6; j++) begin
            ea[j]    = 16'(16'h1111 * (j + 1));
            eb[j]    = 16'(16'h0F0F + j);
            exp_l[j] = model(ea[j], eb[j], 1'b0, 1'b0);
        end
        for (int t = 0; t < 40 && got.size() < 6; t++) begin
            r = !(t >= 5 && t <= 7);
            v = (sent < 6);
            step(v, v ? ea[sent] : 16'h0, v ? eb[sent] : 16'h0, 1'b0, 1'b0, r);
            n_cmp++;
            if (obs_valid === 1'b1 && !r) begin
                stalls++;
                if (obs_in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_in_ready_stall t=%0d: got %b want 0", t, obs_in_ready);
                end
            end else if (obs_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_in_ready_free t=%0d: got %b want 1", t, obs_in_ready);
            end
            if (v && obs_in_ready === 1'b1) sent++;
            if (obs_valid === 1'b1 && r) begin
                g.sum = obs_sum; g.cout = obs_cout; g.ovf = obs_ovf;
                got.push_back(g);
            end
        end
        n_cmp++;
        if (stalls != 3 || got.size() != 6) begin
            n_err++;
            $display("FAIL bp_counts: got stalls=%0d results=%0d, want stalls=3 results=6", stalls, got.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                n_cmp++;
                if (got[j].sum !== exp_l[j].sum || got[j].cout !== exp_l[j].cout) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got sum=%h cout=%b want sum=%h cout=%b",
                             j, got[j].sum, got[j].cout, exp_l[j].sum, exp_l[j].cout);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        for (int t = 0; t < 600; t++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
            step($urandom_range(0, 3) != 0, a, b, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        for (int t = 0; t < 20 && (exp_q.size() != 0 || out_valid === 1'b1); t++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        end
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL random_drain: got %0d pending out_valid=%b, want 0 pending out_valid=0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 5; t++) begin
            step(1'b1, 16'(16'h0A00 + t), 16'h0101, 1'b0, 1'b0, 1'b1);
        end
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got out_valid=%b want 1", out_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_async: got v=%b sum=%h cout=%b ovf=%b rdy=%b, want v=0 sum=0 cout=0 ovf=0 rdy=1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        exp_q.delete();
        prev_stall = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (obs_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_stale t=%0d: got out_valid=%b sum=%h want out_valid=0", t, obs_valid, obs_sum);
            end
        end
        run_single("midrst_new", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
